// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe slice: width arithmetic used to size
// the occupancy counter.
package reg_pipe_pkg;

    // Ceiling log2: the number of bits needed to index `value` distinct items.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One register stage of reg_pipe: a data word plus its valid flag.
// Reset reloads the data; flush only drops the valid flag so the data
// register is left untouched.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] d_reg;
    logic             v_reg;

    // Stage state: reset beats flush, flush beats a load, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_reg <= RESET_VALUE;
            v_reg <= 1'b0;
        end else if (flush) begin
            v_reg <= 1'b0;
        end else if (load) begin
            d_reg <= d_in;
            v_reg <= v_in;
        end
    end

    assign d_out = d_reg;
    assign v_out = v_reg;

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline of DEPTH stages with bubble collapsing.
// Each stage moves forward when the stage after it is empty or is itself
// moving, so back-pressure from out_ready ripples combinationally to
// in_ready while the output stays fully registered.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              OCC_W       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    // Per-stage views; unpacked so the advance chain is a set of
    // independent nets rather than one self-referencing vector.
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
    logic             advance     [DEPTH];

    logic             in_ready_w;
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occupancy_reg;
    logic [OCC_W-1:0] occupancy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] d_in_w;
            logic             v_in_w;
            logic             load_w;

            // Stage 0 takes the upstream port; later stages take their predecessor.
            if (gi == 0) begin : g_head
                assign d_in_w = in_data;
                assign v_in_w = in_valid;
                assign load_w = in_ready_w;
            end else begin : g_body
                assign d_in_w = stage_data[gi-1];
                assign v_in_w = stage_valid[gi-1];
                assign load_w = advance[gi-1];
            end

            // Last stage drains on out_ready; earlier stages move into an
            // empty or moving successor (this is what collapses bubbles).
            if (gi == DEPTH - 1) begin : g_tail
                assign advance[gi] = out_ready;
            end else begin : g_mid
                assign advance[gi] = !stage_valid[gi+1] || advance[gi+1];
            end

            reg_pipe_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .flush (flush),
                .load  (load_w),
                .d_in  (d_in_w),
                .v_in  (v_in_w),
                .d_out (stage_data[gi]),
                .v_out (stage_valid[gi])
            );
        end
    endgenerate

    assign in_ready_w = !flush && (!stage_valid[0] || advance[0]);
    assign in_ready   = in_ready_w;
    assign out_valid  = stage_valid[DEPTH-1] && !flush;
    assign out_data   = stage_data[DEPTH-1];

    assign in_fire  = in_valid && in_ready_w;
    assign out_fire = out_valid && out_ready;

    // Next occupancy: net change of one at most, cleared by flush.
    always_comb begin
        occupancy_next = occupancy_reg;
        if (flush) begin
            occupancy_next = '0;
        end else if (in_fire && !out_fire) begin
            occupancy_next = occupancy_reg + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occupancy_next = occupancy_reg - OCC_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
// The reference model is a queue of accepted words tagged with their
// acceptance cycle: a word may leave once it is at the head and at least
// DEPTH cycles old; input is accepted when fewer than DEPTH words are held
// or the output is being drained.
module tb_reg_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    reg_pipe #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [7:0] data;
        int         acc;
    } ent_t;

    ent_t exp_q[$];
    ent_t p_ent;
    bit   p_push;
    bit   p_clear;
    int   cyc;
    int   checks;
    int   failures;
    bit   prev_hold;
    logic [7:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; model effects of the previous cycle are committed
    // at the edge that makes them real in the DUT.
    task automatic drive(input bit rst, input bit fl, input bit iv,
                         input logic [7:0] dat, input bit ordy);
        @(posedge clk);
        if (p_clear) exp_q.delete();
        else if (p_push) exp_q.push_back(p_ent);
        p_clear = 0;
        p_push  = 0;
        #1;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        if (rst || fl) begin
            p_clear = 1;
        end else if (iv && (exp_q.size() < DEPTH || ordy)) begin
            p_push     = 1;
            p_ent.data = dat;
            p_ent.acc  = cyc;
            $display("IN  cycle=%0d data=%02h", cyc, dat);
        end
    endtask

    task automatic check_post_reset(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'(RV));
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Monitor: compares DUT handshake/status against the model every cycle
    // and pops the scoreboard when a word is handed downstream.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_hold = 0;
        end else begin
            bit exp_ov;
            exp_ov = !flush && exp_q.size() > 0 && (cyc - exp_q[0].acc) >= DEPTH;
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready),
                32'(!flush && (exp_q.size() < DEPTH || out_ready)));
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            if (prev_hold) chk("hold_stable", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %02h expected no output (cycle %0d)",
                             out_data, cyc);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                    $display("OUT cycle=%0d data=%02h", cyc, out_data);
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        p_push    = 0;
        p_clear   = 0;
        prev_hold = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset for two cycles, then the idle post-reset state.
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 0);
        check_post_reset("reset");

        // Streaming 01..08 with the output always ready.
        for (int i = 1; i <= 8; i++) drive(0, 0, 1, 8'(i), 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 8'h00, 1);

        // Stall: fill with 10..12 while blocked, then offer 13 (must be refused).
        drive(0, 0, 1, 8'h10, 0);
        drive(0, 0, 1, 8'h11, 0);
        drive(0, 0, 1, 8'h12, 0);
        drive(0, 0, 1, 8'h13, 0);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_data", 32'(out_data), 32'h10);
        chk("stall_occupancy", 32'(occupancy), 32'd3);
        // Full pass-through: drain one and accept 20 in the same cycle.
        drive(0, 0, 1, 8'h20, 1);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 8'h00, 1);

        // Flush at occupancy 2 while offering 30.
        drive(0, 0, 1, 8'h21, 0);
        drive(0, 0, 1, 8'h22, 0);
        drive(0, 1, 1, 8'h30, 0);
        drive(0, 0, 0, 8'h00, 1);
        @(negedge clk);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 1);

        // Reset with the pipe full, then reset and flush together.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h40 + 8'(i), 0);
        drive(1, 0, 1, 8'h4F, 1);
        drive(0, 0, 0, 8'h00, 0);
        check_post_reset("midreset");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h50 + 8'(i), 0);
        drive(1, 1, 1, 8'h5F, 1);
        drive(0, 0, 0, 8'h00, 0);
        check_post_reset("rstflush");
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            bit r_rst;
            bit r_fl;
            r_rst = ($urandom_range(0, 99) < 1);
            r_fl  = ($urandom_range(0, 99) < 3);
            drive(r_rst, r_fl, ($urandom_range(0, 9) < 7), 8'($urandom),
                  ($urandom_range(0, 9) < 6));
        end

        // Drain and confirm every accepted word came out.
        for (int i = 0; i < DEPTH + 4; i++) drive(0, 0, 0, 8'h00, 1);
        @(posedge clk);
        if (p_clear) exp_q.delete();
        else if (p_push) exp_q.push_back(p_ent);
        p_clear = 0;
        p_push  = 0;
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (min 1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (min 1).
REQ-003 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into every data register on reset.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-007 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-008 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-009 SHALL have port in_ready, output, 1, pipe accepts in_data this cycle.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a valid entry.
REQ-011 SHALL have port out_data, output, WIDTH, payload of the last stage.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-013 SHALL have port occupancy, output, OCC_W = clog2(DEPTH+1), count of valid entries held.

Function
REQ-014 SHALL hold, per stage i (0..DEPTH-1), a data register d[i] and a valid bit v[i]; stage 0 faces the input, and stage DEPTH-1 drives out_data/out_valid directly from registers.
REQ-015 SHALL define advance for the last stage as out_ready, and for stage i<DEPTH-1 as (!v[i+1] || advance[i+1]).
REQ-016 SHALL, when stage i advances, load d[i+1]/v[i+1] from d[i]/v[i]; stage 0 loads in_data/in_valid when in_ready.
REQ-017 SHALL hold a non-advancing stage's d[i] and v[i] unchanged (stall).
REQ-018 SHALL collapse bubbles: an empty stage always accepts from its predecessor regardless of downstream stall.
REQ-019 SHALL drive in_ready = !flush && (!v[0] || advance[0]); the path from out_ready to in_ready is combinational.
REQ-020 SHALL drive out_valid = v[DEPTH-1] && !flush.
REQ-021 SHALL count a transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-022 SHALL update occupancy each cycle by +1 (in only), -1 (out only), or 0 (both or neither); occupancy never exceeds DEPTH.
REQ-023 SHALL give latency of exactly DEPTH cycles from input acceptance to out_valid when out_ready is held high.
REQ-024 SHALL sustain a throughput of one transfer per cycle when in_valid and out_ready are both held high.
REQ-025 SHALL, with flush high, clear every v[i] and occupancy to 0 at the next edge, perform no transfers that cycle, and leave d[i] unchanged.
REQ-026 SHALL drop data presented with in_valid during flush, since in_ready is 0.
REQ-027 SHALL accept a new input in the same cycle the final entry leaves when full (occupancy=DEPTH, out_ready=1), keeping occupancy at DEPTH.
REQ-028 SHALL, with DEPTH=1, behave as a single-entry register slice with in_ready = !flush && (!v[0] || out_ready).
REQ-029 SHALL never change out_data while out_valid && !out_ready.

Reset
REQ-030 SHALL, on reset high at a clock edge, set all v[i]=0, all d[i]=RESET_VALUE, and occupancy=0.
REQ-031 SHALL give reset priority over flush and over all transfers; entries in flight when reset asserts are lost.
REQ-032 SHALL drive in_ready=1 and out_valid=0 in the first cycle after reset deasserts (absent flush).

Structure
REQ-033 SHALL implement one stage as sub-module reg_pipe_stage (WIDTH, RESET_VALUE; ports clk, reset, flush, load, d_in, v_in, d_out, v_out), instantiated DEPTH times via generate.
REQ-034 SHALL provide the clog2 function used for OCC_W from the team's shared utility package; no other shared typedefs or constants are required.

Verification (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5 unless stated)
REQ-035 SHALL cover reset: reset high 2 cycles -> out_valid=0, occupancy=0, out_data=8'hA5, in_ready=1.
REQ-036 SHALL cover streaming: send 8'h01..8'h08 on consecutive cycles with out_ready=1 -> 8'h01 valid 3 cycles after its acceptance, then one word per cycle in order, occupancy steady at 3.
REQ-037 SHALL cover stall and bubbles: hold out_ready=0 while sending 8'h10, 8'h11, 8'h12 -> occupancy=3, in_ready=0, out_data=8'h10 stable; raise out_ready -> 8'h10, 8'h11, 8'h12 emerge on consecutive cycles.
REQ-038 SHALL cover full pass-through: at occupancy=3 with out_ready=1 and in_valid=1 (8'h20) -> in_ready=1, occupancy stays 3, and 8'h20 appears third in line.
REQ-039 SHALL cover flush: occupancy=2 with flush high for 1 cycle and in_valid=1 (8'h30) -> next cycle occupancy=0 and out_valid=0, and 8'h30 never appears.
REQ-040 SHALL cover mid-operation and combined control: reset asserted at occupancy=3, and reset and flush asserted in the same cycle -> next cycle all state equals the post-reset state and no stale word is output.
